// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - sweeps a word range of the data memory through a
// synchronous read port and streams each word out with its dump index.
module dmem_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [CNT_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_data;
  logic                w_accept;
  logic                w_launch;

  assign w_accept = (r_state == S_SEND) && out_ready;
  assign w_launch = (r_state == S_IDLE) && start && (word_count != '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (word_count == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ:  w_next = abort ? S_FIN : S_WAIT;
      S_WAIT: w_next = abort ? S_FIN : S_SEND;
      S_SEND: begin
        // An accept coinciding with abort still retires the word; both end in FIN.
        if (abort) begin
          w_next = S_FIN;
        end else if (w_accept) begin
          w_next = (r_remaining == CNT_W'(1)) ? S_FIN : S_REQ;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
        r_idx       <= '0;
      end
      if ((r_state == S_WAIT) && !abort) begin
        r_data <= mem_rdata;
      end
      // Address wraps naturally at 2**ADDR_W.
      if (w_accept) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_idx       <= r_idx + CNT_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign mem_rd_en = (r_state == S_REQ);
  assign mem_addr  = r_addr;
  assign out_valid = (r_state == S_SEND);
  assign out_data  = r_data;
  assign out_index = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - directed, table-driven bench for dmem_dump_reader.
module tb_dmem_dump_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_index;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  dmem_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .busy       (busy),
    .done       (done)
  );

  logic [DATA_W-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0]        base;
    logic [CNT_W-1:0]         count;
    logic [3:0]               pat;
    int                       abort_word;
    bit                       start_mid;
    int                       nwords;
    int                       nrd;
    logic [7:0][DATA_W-1:0]   exp_data;
    logic [7:0][ADDR_W-1:0]   exp_addr;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q_data[$];
  logic [CNT_W-1:0]  q_idx[$];
  logic [ADDR_W-1:0] q_addr[$];
  int   done_cnt, done_cyc, last_acc, first_valid, abort_cyc;
  logic busy_after, valid_after_abort;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                     input logic [3:0] pat, input int abort_word, input bit start_mid);
    logic pv, pacc, aborted;
    logic [DATA_W-1:0] pd;
    logic [CNT_W-1:0]  pi;
    q_data.delete(); q_idx.delete(); q_addr.delete();
    done_cnt = 0; done_cyc = -1; last_acc = -1; first_valid = -1; abort_cyc = -1;
    busy_after = 1'b1; valid_after_abort = 1'b1;
    pv = 1'b0; pacc = 1'b0; aborted = 1'b0; pd = '0; pi = '0;
    @(negedge clk);
    base_addr = b; word_count = n; start = 1'b1; abort = 1'b0; out_ready = pat[0];
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; out_ready = pat[c % 4];
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (start_mid && c == 5) begin
        start = 1'b1; base_addr = 9'd100; word_count = 10'd1;
      end
      if (mem_rd_en) q_addr.push_back(mem_addr);
      if (abort_cyc >= 0 && c == abort_cyc + 1) valid_after_abort = out_valid;
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (pv && !pacc) begin
          chk("hold_data", 64'(out_data), 64'(pd));
          chk("hold_index", 64'(out_index), 64'(pi));
        end
        if (abort_word >= 0 && !aborted && out_index == CNT_W'(abort_word)) begin
          abort = 1'b1; out_ready = 1'b0; aborted = 1'b1; abort_cyc = c;
        end
      end
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_idx.push_back(out_index);
        last_acc = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      pv = out_valid; pacc = out_valid && out_ready; pd = out_data; pi = out_index;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic check_vec(input int k);
    vec_t v;
    v = vecs[k];
    chk($sformatf("v%0d_nwords", k), 64'(q_data.size()), 64'(v.nwords));
    chk($sformatf("v%0d_nrd", k), 64'(q_addr.size()), 64'(v.nrd));
    for (int i = 0; i < q_data.size() && i < v.nwords; i++) begin
      chk($sformatf("v%0d_data%0d", k, i), 64'(q_data[i]), 64'(v.exp_data[i]));
      chk($sformatf("v%0d_index%0d", k, i), 64'(q_idx[i]), 64'(i));
    end
    for (int i = 0; i < q_addr.size() && i < v.nrd && i < 8; i++) begin
      chk($sformatf("v%0d_addr%0d", k, i), 64'(q_addr[i]), 64'(v.exp_addr[i]));
    end
    chk($sformatf("v%0d_done_cnt", k), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d_busy_after", k), 64'(busy_after), 64'd0);
    if (v.count == '0) begin
      chk($sformatf("v%0d_no_valid", k), 64'(first_valid < 0), 64'd1);
      chk($sformatf("v%0d_done_early", k), 64'(done_cyc >= 1 && done_cyc <= 2), 64'd1);
    end else if (v.abort_word < 0) begin
      chk($sformatf("v%0d_first_valid", k), 64'(first_valid), 64'd3);
      chk($sformatf("v%0d_done_lat", k), 64'(done_cyc - last_acc), 64'd1);
    end else begin
      chk($sformatf("v%0d_valid_drop", k), 64'(valid_after_abort), 64'd0);
      chk($sformatf("v%0d_done_abort", k), 64'(done_cyc - abort_cyc), 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = 1; mem[1] = 1; mem[2] = 2; mem[3] = 3; mem[4] = 5; mem[5] = 8; mem[6] = 13;
    mem[510] = 32'hA510; mem[511] = 32'hA511;

    vecs[0] = '{9'd0, 10'd7, 4'b1111, -1, 1'b0, 7, 7,
                {32'd0, 32'd13, 32'd8, 32'd5, 32'd3, 32'd2, 32'd1, 32'd1},
                {9'd0, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0}};
    vecs[1] = '{9'd0, 10'd7, 4'b1001, -1, 1'b0, 7, 7,
                {32'd0, 32'd13, 32'd8, 32'd5, 32'd3, 32'd2, 32'd1, 32'd1},
                {9'd0, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0}};
    vecs[2] = '{9'd510, 10'd4, 4'b1111, -1, 1'b0, 4, 4,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'hA511, 32'hA510},
                {9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd0, 9'd511, 9'd510}};
    vecs[3] = '{9'd0, 10'd0, 4'b1111, -1, 1'b0, 0, 0, '0, '0};
    vecs[4] = '{9'd0, 10'd7, 4'b1111, -1, 1'b1, 7, 7,
                {32'd0, 32'd13, 32'd8, 32'd5, 32'd3, 32'd2, 32'd1, 32'd1},
                {9'd0, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0}};
    vecs[5] = '{9'd0, 10'd7, 4'b1111, 2, 1'b0, 2, 3,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1},
                {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd2, 9'd1, 9'd0}};

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run(vecs[k].base, vecs[k].count, vecs[k].pat, vecs[k].abort_word, vecs[k].start_mid);
      check_vec(k);
    end

    // Reset asserted in WAIT of the second word.
    @(negedge clk);
    base_addr = 9'd0; word_count = 10'd7; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_index", 64'(out_index), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_index", 64'(out_index), 64'd0);
    chk("async_data", 64'(out_data), 64'd0);
    chk("async_addr", 64'(mem_addr), 64'd0);
    chk("async_valid_rd", 64'({out_valid, mem_rd_en, done}), 64'd0);
    done_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    run(vecs[0].base, vecs[0].count, vecs[0].pat, vecs[0].abort_word, vecs[0].start_mid);
    check_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
